// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/decode instruction queue.
// Holds the queue state encoding, the default datapath widths and the
// canonical RISC-V NOP word (addi x0,x0,0) used when building stimulus.
package fetch_pkg;

  localparam int INSTR_W_DEF = 32;
  localparam int PC_W_DEF    = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Program lifecycle as seen by the queue.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // out of reset, nothing fetched yet
    S_RUN   = 2'd1,  // fetch is streaming instructions in
    S_DRAIN = 2'd2,  // fetch finished; only dequeues remain
    S_DONE  = 2'd3   // everything handed to decode; held until reset
  } fq_state_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: program-ordered {pc, instruction} buffer between Fetch and
// Decode. Fetch advances its PC only on enq_valid && enq_ready, so Decode
// stalls back-pressure fetch without losing instructions. The queue also
// tracks end-of-program so Decode can rely on deq_valid alone.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   enq_valid/instr/pc    instruction offered by Fetch
//   enq_ready             queue accepts the offered instruction this cycle
//   fetch_done            level: Fetch has reached the end of the program
//   deq_valid/instr/pc    head entry presented to Decode (zero when empty)
//   deq_ready             Decode consumes the head this cycle
//   flush                 discard all entries (redirect)
//   count                 number of occupied entries
//   drained               sticky: whole program handed to Decode
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int PC_W    = PC_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_valid,
  input  logic [INSTR_W-1:0]         enq_instr,
  input  logic [PC_W-1:0]            enq_pc,
  output logic                       enq_ready,
  input  logic                       fetch_done,
  output logic                       deq_valid,
  output logic [INSTR_W-1:0]         deq_instr,
  output logic [PC_W-1:0]            deq_pc,
  input  logic                       deq_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drained
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_next;
  fq_state_t        state_q, state_next;

  logic accepting;
  logic enq_fire, deq_fire, flush_eff;

  // Once the program is complete the queue is frozen, so a late redirect
  // cannot reopen it.
  assign flush_eff = flush && (state_q != S_DONE);
  assign accepting = (state_q == S_IDLE) || (state_q == S_RUN);

  // Full blocks enqueue outright, even if a dequeue frees a slot this cycle;
  // this keeps enq_ready independent of deq_ready.
  assign enq_ready = (count_q != FULL) && accepting && !flush;
  assign deq_valid = (count_q != '0) && !flush && (state_q != S_DONE);

  assign enq_fire = enq_valid && enq_ready;
  assign deq_fire = deq_valid && deq_ready;

  assign deq_instr = (count_q != '0) ? instr_mem[head_q] : '0;
  assign deq_pc    = (count_q != '0) ? pc_mem[head_q]    : '0;
  assign count     = count_q;
  assign drained   = (state_q == S_DONE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    count_next = count_q;
    if (flush_eff) begin
      count_next = '0;
    end else begin
      case ({enq_fire, deq_fire})
        2'b10:   count_next = count_q + 1'b1;
        2'b01:   count_next = count_q - 1'b1;
        default: count_next = count_q;
      endcase
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE: begin
        if (enq_fire)        state_next = S_RUN;
        else if (fetch_done) state_next = S_DRAIN;  // empty program
      end
      S_RUN: begin
        // An instruction accepted alongside fetch_done is still kept.
        if (fetch_done) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (count_next == '0) state_next = S_DONE;
      end
      S_DONE:  state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_next;
      count_q <= count_next;
      if (flush_eff) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (deq_fire) head_q <= head_q + 1'b1;  // wraps DEPTH-1 -> 0
        if (enq_fire) tail_q <= tail_q + 1'b1;
      end
    end
  end

  // NOTE: the entry array is deliberately not reset; count gates every read
  // so stale contents are never observed, and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      instr_mem[tail_q] <= enq_instr;
      pc_mem[tail_q]    <= enq_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. A scoreboard queue receives every
// {pc, instr} the bench expects to be accepted; entries are popped and
// compared as Decode consumes them. A small reference model tracks the
// expected count and lifecycle state to predict the handshake outputs.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pair_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enq_valid = 1'b0;
  logic [31:0] enq_instr = '0;
  logic [31:0] enq_pc = '0;
  logic        enq_ready;
  logic        fetch_done = 1'b0;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic        deq_ready = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  count;
  logic        drained;

  fetch_queue #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .enq_valid  (enq_valid),
    .enq_instr  (enq_instr),
    .enq_pc     (enq_pc),
    .enq_ready  (enq_ready),
    .fetch_done (fetch_done),
    .deq_valid  (deq_valid),
    .deq_instr  (deq_instr),
    .deq_pc     (deq_pc),
    .deq_ready  (deq_ready),
    .flush      (flush),
    .count      (count),
    .drained    (drained)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  pair_t     sb[$];
  int        m_count = 0;
  fq_state_t m_state = S_IDLE;

  bit          step_chk = 0;
  bit          have_prev = 0;
  logic [31:0] prev_pc = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return NOP ^ {pc[24:0], 7'b0};
  endfunction

  // Drive one cycle of stimulus at the falling edge, check the outputs the
  // model predicts, then advance the model to the following cycle.
  task automatic cycle(input logic ev, input logic [31:0] pc, input logic [31:0] instr,
                       input logic dr, input logic fd, input logic fl);
    logic  exp_er, exp_dv, en_f, dq_f;
    pair_t hd;
    @(negedge clk);
    reset = 1'b0;
    enq_valid = ev; enq_pc = pc; enq_instr = instr;
    deq_ready = dr; fetch_done = fd; flush = fl;
    #1;
    exp_er = (m_count < DEPTH) && (m_state == S_IDLE || m_state == S_RUN) && !fl;
    exp_dv = (m_count != 0) && !fl && (m_state != S_DONE);
    check("count", 64'(count), 64'(m_count));
    check("enq_ready", 64'(enq_ready), 64'(exp_er));
    check("deq_valid", 64'(deq_valid), 64'(exp_dv));
    check("drained", 64'(drained), 64'(m_state == S_DONE));
    if (m_count == 0) begin
      check("deq_pc_zero", 64'(deq_pc), 64'(0));
      check("deq_instr_zero", 64'(deq_instr), 64'(0));
    end else begin
      hd = sb[0];
      check("deq_pc", 64'(deq_pc), 64'(hd.pc));
      check("deq_instr", 64'(deq_instr), 64'(hd.instr));
    end
    en_f = ev && exp_er;
    dq_f = exp_dv && dr;
    if (dq_f && step_chk) begin
      if (have_prev) check("pc_step", 64'(deq_pc), 64'(prev_pc + 32'd4));
      prev_pc = deq_pc;
      have_prev = 1;
    end
    if (fl && m_state != S_DONE) begin
      sb.delete();
      m_count = 0;
    end else begin
      if (dq_f) void'(sb.pop_front());
      if (en_f) sb.push_back('{pc: pc, instr: instr});
      m_count = m_count + int'(en_f) - int'(dq_f);
    end
    case (m_state)
      S_IDLE:  if (en_f) m_state = S_RUN; else if (fd) m_state = S_DRAIN;
      S_RUN:   if (fd) m_state = S_DRAIN;
      S_DRAIN: if (m_count == 0) m_state = S_DONE;
      default: m_state = m_state;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    enq_valid = 1'b0; deq_ready = 1'b0; fetch_done = 1'b0; flush = 1'b0;
    sb.delete();
    m_count = 0;
    m_state = S_IDLE;
  endtask

  task automatic enq(input logic [31:0] pc);
    cycle(1'b1, pc, mk_instr(pc), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic dr, input logic fd);
    cycle(1'b0, 32'h0, 32'h0, dr, fd, 1'b0);
  endtask

  initial begin
    // Reset state, then basic fill with the three-instruction program.
    do_reset();
    idle(1'b0, 1'b0);
    cycle(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h4, 32'h00A0_0113, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h8, 32'h0020_81B3, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("fill_count", 64'(count), 64'(3));
    check("fill_head_instr", 64'(deq_instr), 64'(32'h0050_0093));

    // Full, ignored 9th enqueue, then wrap the pointers.
    do_reset();
    for (int i = 0; i < DEPTH; i++) enq(32'(i * 4));
    enq(32'h20);                       // refused: queue full
    check("full_count", 64'(count), 64'(DEPTH));
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) enq(32'h20 + 32'(i * 4));
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1, 1'b0);

    // Simultaneous enqueue/dequeue at count 4: steady count, +4 PC stream.
    do_reset();
    for (int i = 0; i < 4; i++) enq(32'(i * 4));
    step_chk = 1; have_prev = 0;
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'(16 + i * 4), mk_instr(32'(16 + i * 4)), 1'b1, 1'b0, 1'b0);
    step_chk = 0;
    idle(1'b0, 1'b0);

    // End of program: fetch_done with the 5th enqueue, then drain.
    do_reset();
    for (int i = 0; i < 4; i++) enq(32'h100 + 32'(i * 4));
    cycle(1'b1, 32'h110, mk_instr(32'h110), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) idle(1'b1, 1'b1);
    check("prog_drained", 64'(drained), 64'(1));
    cycle(1'b1, 32'h200, mk_instr(32'h200), 1'b1, 1'b1, 1'b1);  // flush ignored when done

    // Flush with a concurrent enqueue attempt.
    do_reset();
    for (int i = 0; i < 6; i++) enq(32'h40 + 32'(i * 4));
    cycle(1'b1, 32'h58, mk_instr(32'h58), 1'b1, 1'b0, 1'b1);
    idle(1'b0, 1'b0);
    enq(32'h300);
    idle(1'b1, 1'b0);

    // Empty program goes straight to done.
    do_reset();
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);

    // Reset while draining with three entries outstanding.
    do_reset();
    for (int i = 0; i < 2; i++) enq(32'h80 + 32'(i * 4));
    cycle(1'b1, 32'h88, mk_instr(32'h88), 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1);
    check("pre_reset_count", 64'(count), 64'(3));
    do_reset();
    idle(1'b0, 1'b0);
    enq(32'h400);
    idle(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
